// File: rtl/spi_tx_pkg.sv
// Shared definitions for the SPI transmit engine: FSM state encoding and a
// counter-width helper used to size counters and the FIFO occupancy port.
package spi_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // ceil(log2(n)), never less than 1 so single-value counters still get a bit
  function automatic int clog2(input int n);
    int r;
    for (r = 1; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Small synchronous FIFO for queued SPI words; head entry is read combinationally.
module spi_tx_fifo
  import spi_tx_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic                        empty,
  output logic                        full,
  output logic [clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // full blocks pushes even when a pop happens in the same cycle
  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/spi_tx_engine.sv
// SPI transmit engine: queues {dc,data} words and shifts them out in CS frames.
// Define SPI_TX_LSB_FIRST_EN to send bit 0 first (default: MSB first).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | CS high, SCK idle; wait for a queued word
// ST_SETUP | CS low, first bit on MOSI, one half-period before first edge
// ST_SHIFT | leading/trailing half-periods per bit, back-to-back words
// ST_HOLD  | CS still low, SCK idle for one half-period, then release
module spi_tx_engine
  import spi_tx_pkg::*;
#(
  parameter int   WIDTH   = 8,
  parameter int   DEPTH   = 4,
  parameter int   CLK_DIV = 2,
  parameter logic CPOL    = 1'b1
) (
  input  logic                        i_CLK,
  input  logic                        i_RST_N,
  input  logic [WIDTH-1:0]            i_DATA,
  input  logic                        i_DC,
  input  logic                        i_VALID,
  output logic                        o_READY,
  output logic                        o_SCK,
  output logic                        o_MOSI,
  output logic                        o_CS,
  output logic                        o_DC,
  output logic                        o_DONE,
  output logic                        o_BUSY,
  output logic [clog2(DEPTH+1)-1:0]   o_LEVEL
);

  localparam int             DW       = clog2(CLK_DIV);
  localparam int             BW       = clog2(WIDTH);
  localparam logic [DW-1:0]  DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0]  BIT_LOAD = BW'(WIDTH - 1);

  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             leading;
  logic [WIDTH:0]   head;
  logic             empty;
  logic             full;
  logic             pop;
  logic             tick;
  logic             last_half;

`ifdef SPI_TX_LSB_FIRST_EN
  function automatic logic first_bit(input logic [WIDTH-1:0] d);
    return d[0];
  endfunction
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
    return d >> 1;
  endfunction
`else
  function automatic logic first_bit(input logic [WIDTH-1:0] d);
    return d[WIDTH-1];
  endfunction
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
    return d << 1;
  endfunction
`endif

  spi_tx_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_CLK),
    .rst_n     (i_RST_N),
    .push      (i_VALID),
    .push_data ({i_DC, i_DATA}),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .level     (o_LEVEL)
  );

  assign tick      = (div_cnt == '0);
  assign last_half = (state == ST_SHIFT) && tick && !leading && (bit_cnt == '0);
  assign o_READY   = !full;
  assign o_BUSY    = (state != ST_IDLE);

  always_comb begin
    pop = 1'b0;
    if (!empty && ((state == ST_IDLE) || last_half)) pop = 1'b1;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state   <= ST_IDLE;
      div_cnt <= DIV_LOAD;
      bit_cnt <= BIT_LOAD;
      shreg   <= '0;
      leading <= 1'b0;
      o_SCK   <= CPOL;
      o_CS    <= 1'b1;
      o_MOSI  <= 1'b0;
      o_DC    <= 1'b0;
      o_DONE  <= 1'b0;
    end else begin
      o_DONE  <= 1'b0;
      div_cnt <= tick ? DIV_LOAD : div_cnt - 1'b1;
      case (state)
        ST_IDLE: begin
          o_CS  <= 1'b1;
          o_SCK <= CPOL;
          if (!empty) begin
            state   <= ST_SETUP;
            div_cnt <= DIV_LOAD;
            o_CS    <= 1'b0;
            shreg   <= head[WIDTH-1:0];
            o_MOSI  <= first_bit(head[WIDTH-1:0]);
            o_DC    <= head[WIDTH];
          end
        end
        ST_SETUP: begin
          if (tick) begin
            state   <= ST_SHIFT;
            o_SCK   <= ~CPOL;
            leading <= 1'b1;
            bit_cnt <= BIT_LOAD;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (leading) begin
              o_SCK   <= CPOL;
              leading <= 1'b0;
            end else if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              shreg   <= advance(shreg);
              o_MOSI  <= first_bit(advance(shreg));
              o_SCK   <= ~CPOL;
              leading <= 1'b1;
            end else begin
              o_DONE <= 1'b1;
              // chain the next queued word without releasing CS
              if (!empty) begin
                shreg   <= head[WIDTH-1:0];
                o_MOSI  <= first_bit(head[WIDTH-1:0]);
                o_DC    <= head[WIDTH];
                bit_cnt <= BIT_LOAD;
                o_SCK   <= ~CPOL;
                leading <= 1'b1;
              end else begin
                state <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state <= ST_IDLE;
            o_CS  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_tx_engine.md
SPI_TX_ENGINE -- requirements
Module: spi_tx_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per word (1..32).
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter CLK_DIV, default 2, i_CLK cycles per SCK half-period (>=1).
REQ-004 SHALL have parameter CPOL, default 1, SCK idle level.
REQ-005 SHALL have port i_CLK, input, 1, single system clock; all state on rising edge.
REQ-006 SHALL have port i_RST_N, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_DATA, input, WIDTH, word to transmit.
REQ-008 SHALL have port i_DC, input, 1, data/command flag stored with word.
REQ-009 SHALL have port i_VALID, input, 1, push request.
REQ-010 SHALL have port o_READY, output, 1, FIFO not full.
REQ-011 SHALL have ports o_SCK, o_MOSI, o_CS (active low), o_DC, each output, 1.
REQ-012 SHALL have port o_DONE, output, 1, one-cycle pulse per word completed.
REQ-013 SHALL have ports o_BUSY, output, 1 (state != IDLE), and o_LEVEL, output, clog2(DEPTH+1), FIFO occupancy.

Function
REQ-014 SHALL push {i_DC,i_DATA} when i_VALID && o_READY; i_VALID with o_READY=0 SHALL be dropped.
REQ-015 SHALL deassert o_READY when o_LEVEL==DEPTH, including cycles with a simultaneous pop.
REQ-016 SHALL leave o_LEVEL unchanged on simultaneous push and pop.
REQ-017 SHALL use states IDLE, SETUP, SHIFT, HOLD; half-period tick every CLK_DIV cycles via counter cleared on each state entry.
REQ-018 IDLE: on FIFO non-empty at edge k, SHALL enter SETUP at edge k+1 popping one entry, driving o_CS=0, o_MOSI=first bit, o_DC=stored DC.
REQ-019 SETUP SHALL last one half-period with o_SCK=CPOL, then enter SHIFT.
REQ-020 SHIFT: each bit SHALL be one leading half (o_SCK=~CPOL) then one trailing half (o_SCK=CPOL); o_MOSI SHALL change only at start of leading-to-trailing complete, i.e. at the trailing-to-next-leading boundary.
REQ-021 On end of last bit's trailing half, SHALL pulse o_DONE for one cycle.
REQ-022 Same cycle, if FIFO non-empty, SHALL pop, load o_MOSI/o_DC from new entry, stay in SHIFT with o_CS held low (no gap bits).
REQ-023 Else SHALL enter HOLD: o_CS low, o_SCK=CPOL for one half-period, then IDLE with o_CS=1.
REQ-024 A word pushed during HOLD SHALL start a new frame via IDLE→SETUP (CS high for at least one cycle).
REQ-025 Single-word frame SHALL hold o_CS low for (2*WIDTH+2)*CLK_DIV cycles.
REQ-026 In IDLE, o_SCK=CPOL, o_CS=1, o_MOSI and o_DC SHALL hold last value.

Reset
REQ-027 i_RST_N low SHALL immediately force IDLE, FIFO empty, o_CS=1, o_SCK=CPOL, o_MOSI=0, o_DC=0, o_DONE=0, o_BUSY=0, o_LEVEL=0, o_READY=1.
REQ-028 Reset mid-word SHALL abort the word with no o_DONE pulse; all queued entries discarded.

Configuration
REQ-029 With SPI_TX_LSB_FIRST_EN defined, SHALL shift i_DATA[0] first; undefined, SHALL shift i_DATA[WIDTH-1] first; port list identical in both.

Structure
REQ-030 Shared package spi_tx_pkg SHALL hold state encoding and counter-width function (clog2).
REQ-031 FIFO SHALL be sub-module spi_tx_fifo (registered storage, first-word read combinationally).

Verification
REQ-032 WIDTH=8,CLK_DIV=2,CPOL=1: push 0xA5 DC=1 → CS low 36 cycles, MOSI bits 1,0,1,0,0,1,0,1, stable at rising SCK, o_DC=1, one o_DONE.
REQ-033 Push 0x15 DC=0 then 0xAF DC=1 back-to-back → CS low continuously, 16 SCK pulses, o_DC flips at word 2 first bit, two o_DONE.
REQ-034 Push 5 words into DEPTH=4 while idle-blocked → o_READY=0 at level 4, fifth word dropped unless pushed after first pop.
REQ-035 Assert i_RST_N=0 after 3 bits of 0xFF → CS=1, SCK=1, MOSI=0, o_LEVEL=0 immediately, no o_DONE.
REQ-036 With SPI_TX_LSB_FIRST_EN, push 0x01 → MOSI 1 then seven 0s.
REQ-037 CPOL=0,CLK_DIV=1: push 0x80 → SCK idles 0, first bit 1, CS low 18 cycles.
